min_max_decimator: RTL
======================

// Module: min_max_decimator
// PURPOSE
//  Consumes the CLK_EN window strobe from the decimation counter and the raw ADC
//  sample stream (one sample per CLK). Per decimation window it either forwards
//  one sample (normal mode) or tracks the window minimum and maximum (peak-detect
//  mode). Results go out as single-byte writes with an incrementing wrapping
//  address to the sample capture RAM. It sits between the decimation counter and
//  the RAM write port.
// PARAMETERS
//  DATA_W   8    sample width, bits
//  ADDR_W   17   capture RAM address width
// PORTS
//  CLK          in   1        system clock, all logic on posedge
//  RST          in   1        synchronous, active-high reset
//  Start_WR     in   1        capture enable (same signal that drives the decimation counter)
//  CLK_EN       in   1        window-end strobe from the decimation counter
//  PEAK_MODE    in   1        1 = min/max peak detect, 0 = plain decimation; sampled on Start_WR rise only
//  DATA_IN      in   DATA_W   ADC sample, valid every CLK
//  WR_EN        out  1        RAM write strobe, one cycle per word
//  WR_ADDR      out  ADDR_W   RAM address of the current write
//  DATA_OUT     out  DATA_W   RAM write data
//  MIN_MAX_SEL  out  1        0 = min or plain sample, 1 = max; valid with WR_EN
//  WRAPPED      out  1        sticky: WR_ADDR has wrapped from all-ones to 0
//  OVERRUN      out  1        sticky: a window closed while a peak pair was still being written
// BEHAVIOUR
//  Reset: WR_EN=0, WR_ADDR=0, DATA_OUT=0, MIN_MAX_SEL=0, WRAPPED=0, OVERRUN=0.
//   Internal state goes to IDLE, window invalid, mode register=0.
//  Start_WR=0: same as reset, except outputs hold no pending writes. Any write in
//   flight is dropped; a pending max write is never emitted.
//  Start_WR 0->1 (registered edge): latch PEAK_MODE; clear WR_ADDR, WRAPPED, OVERRUN;
//   mark window invalid. The first sample after the edge opens a window.
//  Window tracking (peak mode): if the window is invalid, load cur_min=cur_max=DATA_IN
//   and mark it valid. Otherwise compare unsigned:
//   cur_min=min(cur_min,DATA_IN), cur_max=max(cur_max,DATA_IN).
//  Window close: the cycle T with Start_WR=1 and CLK_EN=1. The sample at T belongs
//   to the closing window. Final min/max include DATA_IN@T and are latched into
//   out_min/out_max. The window becomes invalid, so the sample at T+1 opens a new one.
//  FSM {IDLE, WR_MIN, WR_MAX}, registered outputs:
//   IDLE  --close, peak--> WR_MIN;  IDLE --close, plain--> WR_MIN (single write).
//   WR_MIN: WR_EN=1, DATA_OUT=out_min (plain: sample@T), MIN_MAX_SEL=0.
//     Next state is WR_MAX (peak) or IDLE (plain). A close in this cycle in plain
//     mode re-enters WR_MIN.
//   WR_MAX: WR_EN=1, DATA_OUT=out_max, MIN_MAX_SEL=1. Next state is IDLE, or WR_MIN
//     if a close occurs in this cycle.
//  Latency: close at T -> first write at T+1; peak max at T+2.
//  Overrun: in peak mode a close while the FSM is in WR_MIN is dropped and OVERRUN
//   is set. That window's result is lost; the new window still opens at T+1.
//   Peak mode therefore needs CLK_EN spacing >= 2 cycles, i.e. decimation >= 1.
//  Plain mode sustains a close every cycle (decimation 0): back-to-back WR_EN.
//  Address: WR_ADDR advances by 1 in the cycle after each WR_EN. It wraps
//   2^ADDR_W-1 -> 0, and WRAPPED is set on the wrap. It holds when WR_EN=0.
//  CLK_EN while Start_WR=0 is ignored.
//  PEAK_MODE changes mid-capture are ignored until the next Start_WR rise.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/WR_MIN/WR_MAX) and the MIN_MAX_SEL
//   codes (SEL_MIN=0, SEL_MAX=1), shared with the RAM read-back/display path.
//  One sub-module: peak_tracker (cur_min/cur_max registers, window-valid flag,
//   unsigned compares, close latch). The FSM and address counter stay in the top.
// TESTING
//  1 Plain mode, CLK_EN every 4 cycles, DATA_IN ramp 0,1,2.. -> writes 3,7,11 at
//    addr 0,1,2, each one cycle after the strobe, MIN_MAX_SEL=0.
//  2 Peak mode, window samples 40,10,200,90 with close on 90 -> T+1 write 10 sel=0
//    addr0; T+2 write 200 sel=1 addr1.
//  3 Peak mode, CLK_EN on consecutive cycles -> second close dropped, OVERRUN=1,
//    only the first pair is written, addresses stay contiguous.
//  4 ADDR_W=3, plain mode, 9 closes -> address sequence 0..7,0; WRAPPED rises with
//    the wrap and stays set.
//  5 Start_WR dropped in the cycle between a min and a max write -> no max write,
//    WR_EN=0 next cycle. Re-raise -> WR_ADDR=0, flags cleared, the new first window
//    starts fresh (no stale min/max).
//  6 RST asserted mid-capture with the FSM in WR_MAX -> next cycle all outputs at
//    reset values, no WR_EN until a new close after Start_WR rise.

Source files
------------

// File: rtl/min_max_decimator_pkg.sv
// Shared definitions for the capture write path: write FSM encoding and the
// MIN_MAX_SEL codes also decoded by the RAM read-back/display path.
package min_max_decimator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_MIN = 2'd1,
        WR_MAX = 2'd2
    } wr_state_t;

    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_MAX = 1'b1;

endpackage

// File: rtl/min_max_decimator_peak_tracker.sv
// Running unsigned min/max over one decimation window. win_min/win_max already
// include the current sample so the closing cycle's sample is part of the result.
module min_max_decimator_peak_tracker #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic              close,
    input  logic              latch,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] win_min,
    output logic [DATA_W-1:0] win_max,
    output logic [DATA_W-1:0] out_max
);

    logic              valid;
    logic [DATA_W-1:0] cur_min;
    logic [DATA_W-1:0] cur_max;

    always_comb begin
        win_min = data_in;
        win_max = data_in;
        if (valid) begin
            win_min = (data_in < cur_min) ? data_in : cur_min;
            win_max = (data_in > cur_max) ? data_in : cur_max;
        end
    end

    // Any close (accepted or dropped) ends the window; next sample reopens it.
    always_ff @(posedge clk) begin
        if (rst || !active) begin
            valid <= 1'b0;
        end else begin
            valid <= !close;
        end
    end

    always_ff @(posedge clk) begin
        cur_min <= win_min;
        cur_max <= win_max;
        if (latch) begin
            out_max <= win_max;
        end
    end

endmodule

// File: rtl/min_max_decimator.sv
// Per-window decimation / peak detection feeding byte writes with a wrapping
// address into the sample capture RAM.
module min_max_decimator
    import min_max_decimator_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 17
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start_WR,
    input  logic              CLK_EN,
    input  logic              PEAK_MODE,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              MIN_MAX_SEL,
    output logic              WRAPPED,
    output logic              OVERRUN
);

    wr_state_t         state;
    wr_state_t         state_nxt;
    logic              start_q;
    logic              mode_q;
    logic              rise;
    logic              peak;
    logic              close;
    logic              accept;
    logic              ovr;
    logic [DATA_W-1:0] data_nxt;
    logic [DATA_W-1:0] win_min;
    logic [DATA_W-1:0] win_max;
    logic [DATA_W-1:0] out_max;

    assign rise  = Start_WR && !start_q;
    // The mode is taken live in the rise cycle so a close there uses the new mode.
    assign peak  = rise ? PEAK_MODE : mode_q;
    assign close = Start_WR && CLK_EN;

    min_max_decimator_peak_tracker #(
        .DATA_W (DATA_W)
    ) u_tracker (
        .clk     (CLK),
        .rst     (RST),
        .active  (Start_WR),
        .close   (close),
        .latch   (accept),
        .data_in (DATA_IN),
        .win_min (win_min),
        .win_max (win_max),
        .out_max (out_max)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ovr       = 1'b0;
        if (!Start_WR) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (close) begin
                        state_nxt = WR_MIN;
                        accept    = 1'b1;
                    end
                end
                WR_MIN: begin
                    if (peak) begin
                        state_nxt = WR_MAX;
                        ovr       = close;
                    end else if (close) begin
                        state_nxt = WR_MIN;
                        accept    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                WR_MAX: begin
                    if (close) begin
                        state_nxt = WR_MIN;
                        accept    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        data_nxt = DATA_OUT;
        case (state_nxt)
            WR_MIN:  data_nxt = peak ? win_min : DATA_IN;
            WR_MAX:  data_nxt = out_max;
            default: data_nxt = DATA_OUT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            mode_q      <= 1'b0;
            WR_EN       <= 1'b0;
            DATA_OUT    <= '0;
            MIN_MAX_SEL <= SEL_MIN;
            WR_ADDR     <= '0;
            WRAPPED     <= 1'b0;
            OVERRUN     <= 1'b0;
        end else begin
            start_q     <= Start_WR;
            state       <= state_nxt;
            WR_EN       <= (state_nxt != IDLE);
            DATA_OUT    <= data_nxt;
            MIN_MAX_SEL <= (state_nxt == WR_MAX) ? SEL_MAX : SEL_MIN;
            if (rise) begin
                mode_q  <= PEAK_MODE;
                WR_ADDR <= '0;
                WRAPPED <= 1'b0;
                OVERRUN <= 1'b0;
            end else begin
                // Address follows the write that is on the bus this cycle.
                if (WR_EN) begin
                    WR_ADDR <= WR_ADDR + ADDR_W'(1);
                    if (&WR_ADDR) begin
                        WRAPPED <= 1'b1;
                    end
                end
                if (ovr) begin
                    OVERRUN <= 1'b1;
                end
            end
        end
    end

endmodule
